// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
//
// Bundles the producer-facing write port and the transmitter-facing load port
// of uart_tx_fifo. Signal names keep the i_/o_ prefixes as seen from the FIFO,
// so the same names appear in the FIFO body and in any bound checker.
//
// Handshake semantics:
//   Write side: i_wr is a strobe, one word per cycle while high. There is no
//   per-beat ready; the producer watches o_full. A write presented while
//   o_full=1 is dropped and reported by a one-cycle o_overflow pulse.
//   Transmit side: i_tx_available high means the transmitter is idle.
//   o_tx_data_ready is a one-cycle load pulse, only ever raised in a cycle
//   where i_tx_available was high at the launching edge; o_tx_data is valid
//   during that pulse and holds until the next load.
//
// Modports:
//   master : producer + transmitter side (drives i_*, observes o_*)
//   slave  : the FIFO itself (drives o_*, observes i_*)
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if #(
    parameter int DATA_BITS       = 8,
    parameter int FIFO_DEPTH_LOG2 = 4
);
    // Producer write port
    logic                       i_wr;
    logic [DATA_BITS-1:0]       i_wdata;
    logic                       o_full;
    logic                       o_empty;
    logic [FIFO_DEPTH_LOG2:0]   o_count;
    logic                       o_overflow;

    // Transmitter load port
    logic                       i_tx_available;
    logic [DATA_BITS-1:0]       o_tx_data;
    logic                       o_tx_data_ready;

    modport master (
        output i_wr,
        output i_wdata,
        output i_tx_available,
        input  o_full,
        input  o_empty,
        input  o_count,
        input  o_overflow,
        input  o_tx_data,
        input  o_tx_data_ready
    );

    modport slave (
        input  i_wr,
        input  i_wdata,
        input  i_tx_available,
        output o_full,
        output o_empty,
        output o_count,
        output o_overflow,
        output o_tx_data,
        output o_tx_data_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Transmit-side buffer in front of the UART transmitter. Producers push bytes
// at any rate into a circular register FIFO; a small FSM hands them to the
// transmitter one at a time with a single-cycle load pulse, then waits for the
// transmitter to go busy and come back idle before offering the next byte.
//
// Ports:
//   i_clock  : system clock, all logic on the rising edge
//   i_reset  : synchronous, active-high reset; overrides everything
//   bus      : uart_tx_fifo_if.slave
//                i_wr / i_wdata        write strobe and data
//                o_full / o_empty      decoded from registered count
//                o_count               current occupancy (0..2^FIFO_DEPTH_LOG2)
//                o_overflow            one-cycle pulse, write dropped (full)
//                i_tx_available        transmitter idle
//                o_tx_data             registered byte for the transmitter
//                o_tx_data_ready       registered one-cycle load pulse
//   o_state  : debug view of the one-hot FSM state
//                3'b001 IDLE, 3'b010 WAIT_BUSY, 3'b100 WAIT_DONE
//
// The bus interface must be instantiated with the same DATA_BITS and
// FIFO_DEPTH_LOG2 as this module.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DATA_BITS       = 8,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    uart_tx_fifo_if.slave        bus,
    output logic [2:0]           o_state
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int PW    = FIFO_DEPTH_LOG2;

    localparam logic [CW-1:0] COUNT_ZERO = '0;
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'b001,
        WAIT_BUSY = 3'b010,
        WAIT_DONE = 3'b100
    } state_t;

    // -------------------------------------------------------------------------
    // Storage and bookkeeping
    // -------------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 overflow_q;
    logic [DATA_BITS-1:0] tx_data_q;
    logic                 tx_data_ready_q;

    state_t               state_q;
    state_t               state_d;
    logic                 pop;

    logic                 full;
    logic                 empty;
    logic                 wr_accept;
    logic                 wr_drop;

    // Status comes only from the registered count, so o_full/o_empty have no
    // combinational path from i_wr.
    assign full  = (count_q == COUNT_FULL);
    assign empty = (count_q == COUNT_ZERO);

    // Acceptance looks only at the pre-edge full flag; a pop on the same edge
    // does not make room for a write that arrives while full.
    assign wr_accept = bus.i_wr && !full;
    assign wr_drop   = bus.i_wr &&  full;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and pop decision
    //
    // The pop is only taken on the edge that leaves IDLE. Because count_q is
    // registered, a word written on edge N first becomes visible to this
    // decision for edge N+1, so there is no write-through path.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty && bus.i_tx_available) begin
                    pop     = 1'b1;
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // Transmitter has to acknowledge the load by going busy.
                if (!bus.i_tx_available) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.i_tx_available) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Pointers and occupancy
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers are exactly log2(depth) wide and wrap naturally.
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            unique case ({wr_accept, pop})
                2'b10:   count_q <= count_q + COUNT_ONE;
                2'b01:   count_q <= count_q - COUNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Array carries no reset; reset discards contents through the pointers.
    always_ff @(posedge i_clock) begin
        if (!i_reset && wr_accept) begin
            mem[wr_ptr_q] <= bus.i_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            overflow_q      <= 1'b0;
            tx_data_q       <= '0;
            tx_data_ready_q <= 1'b0;
        end else begin
            overflow_q      <= wr_drop;
            // The load pulse mirrors the pop, so it lasts exactly one cycle and
            // can only follow an edge where the transmitter was available.
            tx_data_ready_q <= pop;
            // Data is held after the pulse until the next pop.
            if (pop) begin
                tx_data_q <= mem[rd_ptr_q];
            end
        end
    end

    assign bus.o_full          = full;
    assign bus.o_empty         = empty;
    assign bus.o_count         = count_q;
    assign bus.o_overflow      = overflow_q;
    assign bus.o_tx_data       = tx_data_q;
    assign bus.o_tx_data_ready = tx_data_ready_q;

    assign o_state = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Directed bench for uart_tx_fifo. Inputs are driven on the falling edge,
// outputs are checked on the falling edge. A simple transmitter model can be
// switched in: it drops available one cycle after a load and raises it again
// 160 cycles later. A monitor records every load pulse (data) into rec_q.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DW = 8;
    localparam int LG = 4;

    localparam logic [2:0] ST_IDLE      = 3'b001;
    localparam logic [2:0] ST_WAIT_DONE = 3'b100;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] state_dbg;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_BITS(DW), .FIFO_DEPTH_LOG2(LG)) bus ();

    uart_tx_fifo #(.DATA_BITS(DW), .FIFO_DEPTH_LOG2(LG)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus.slave),
        .o_state (state_dbg)
    );

    // ---------------- transmitter availability ----------------
    logic       drv_avail   = 1'b0;
    logic       tx_model_en = 1'b0;
    logic       model_avail;
    logic       drop_pending;
    int         model_timer;

    assign bus.i_tx_available = tx_model_en ? model_avail : drv_avail;

    always @(posedge clk) begin
        if (rst || !tx_model_en) begin
            model_avail  <= 1'b1;
            drop_pending <= 1'b0;
            model_timer  <= 0;
        end else begin
            if (drop_pending) begin
                model_avail  <= 1'b0;
                model_timer  <= 160;
                drop_pending <= 1'b0;
            end else if (model_timer != 0) begin
                model_timer <= model_timer - 1;
                if (model_timer == 1) model_avail <= 1'b1;
            end
            if (bus.o_tx_data_ready) drop_pending <= 1'b1;
        end
    end

    // ---------------- monitor / scoreboard storage ----------------
    logic [DW-1:0] rec_q[$];
    logic [DW-1:0] exp_q[$];
    int            unsafe_cnt = 0;

    always @(posedge clk) begin
        if (!rst && bus.o_tx_data_ready) begin
            rec_q.push_back(bus.o_tx_data);
            if (!bus.i_tx_available) unsafe_cnt++;
        end
    end

    int tests_run    = 0;
    int tests_failed = 0;

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        tx_model_en = 1'b0;
        bus.i_wr    = 1'b0;
        bus.i_wdata = '0;
        rst         = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rec_q.delete();
        exp_q.delete();
        unsafe_cnt = 0;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        bus.i_wr    = 1'b1;
        bus.i_wdata = d;
        @(negedge clk);
        bus.i_wr    = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int cyc = 0;
        while (rec_q.size() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.i_wr    = 1'b1;
        bus.i_wdata = 8'h77;
        drv_avail   = 1'b1;
        rst         = 1'b1;
        repeat (2) @(negedge clk);
        bus.i_wr = 1'b0;
        tests_run++; if (bus.o_count !== 5'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", bus.o_count); end
        tests_run++; if (bus.o_empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b expected 1", bus.o_empty); end
        tests_run++; if (bus.o_full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b expected 0", bus.o_full); end
        tests_run++; if (bus.o_tx_data_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0", bus.o_tx_data_ready); end
        tests_run++; if (bus.o_tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", bus.o_tx_data); end
        tests_run++; if (bus.o_overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", bus.o_overflow); end
        tests_run++; if (state_dbg !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %b expected %b", state_dbg, ST_IDLE); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_latency();
        apply_reset();
        drv_avail = 1'b1;
        write_word(8'hA5);                      // accepted on edge N
        tests_run++; if (bus.o_tx_data_ready !== 1'b0) begin tests_failed++; $display("FAIL lat_no_early_ready: got %b expected 0", bus.o_tx_data_ready); end
        tests_run++; if (bus.o_count !== 5'd1) begin tests_failed++; $display("FAIL lat_count_after_write: got %0d expected 1", bus.o_count); end
        @(negedge clk);                         // after edge N+1
        tests_run++; if (bus.o_tx_data_ready !== 1'b1) begin tests_failed++; $display("FAIL lat_ready: got %b expected 1", bus.o_tx_data_ready); end
        tests_run++; if (bus.o_tx_data !== 8'hA5) begin tests_failed++; $display("FAIL lat_data: got %h expected a5", bus.o_tx_data); end
        tests_run++; if (bus.o_count !== 5'd0) begin tests_failed++; $display("FAIL lat_count_after_pop: got %0d expected 0", bus.o_count); end
        @(negedge clk);
        tests_run++; if (bus.o_tx_data_ready !== 1'b0) begin tests_failed++; $display("FAIL lat_pulse_width: got %b expected 0", bus.o_tx_data_ready); end
        tests_run++; if (bus.o_tx_data !== 8'hA5) begin tests_failed++; $display("FAIL lat_data_hold: got %h expected a5", bus.o_tx_data); end
        drv_avail = 1'b0;
        @(negedge clk);
        drv_avail = 1'b1;
        @(negedge clk);
        tests_run++; if (state_dbg !== ST_IDLE) begin tests_failed++; $display("FAIL lat_back_to_idle: got %b expected %b", state_dbg, ST_IDLE); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] got;
        apply_reset();
        tx_model_en = 1'b1;
        exp_q = '{8'h11, 8'h22, 8'h33};
        bus.i_wr = 1'b1;
        bus.i_wdata = 8'h11; @(negedge clk);
        bus.i_wdata = 8'h22; @(negedge clk);
        bus.i_wdata = 8'h33; @(negedge clk);
        bus.i_wr = 1'b0;
        wait_pulses(3, 2000);
        repeat (400) @(negedge clk);            // room for any spurious extra pulse
        tests_run++; if (rec_q.size() != 3) begin tests_failed++; $display("FAIL b2b_pulse_count: got %0d expected 3", rec_q.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < rec_q.size()) ? rec_q[i] : 'x;
            tests_run++; if (got !== exp_q[i]) begin tests_failed++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, got, exp_q[i]); end
        end
        tests_run++; if (unsafe_cnt != 0) begin tests_failed++; $display("FAIL b2b_pulse_while_busy: got %0d expected 0", unsafe_cnt); end
    endtask

    task automatic test_overflow_wrap();
        logic [DW-1:0] got;
        int            ff_seen = 0;
        apply_reset();
        drv_avail = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.i_wr    = 1'b1;
            bus.i_wdata = 8'(i);
            exp_q.push_back(8'(i));
            @(negedge clk);
        end
        bus.i_wr = 1'b0;
        tests_run++; if (bus.o_full !== 1'b1) begin tests_failed++; $display("FAIL ovf_full: got %b expected 1", bus.o_full); end
        tests_run++; if (bus.o_count !== 5'd16) begin tests_failed++; $display("FAIL ovf_count16: got %0d expected 16", bus.o_count); end
        tests_run++; if (bus.o_overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_no_early_pulse: got %b expected 0", bus.o_overflow); end
        write_word(8'hFF);
        tests_run++; if (bus.o_overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_pulse: got %b expected 1", bus.o_overflow); end
        tests_run++; if (bus.o_count !== 5'd16) begin tests_failed++; $display("FAIL ovf_count_hold: got %0d expected 16", bus.o_count); end
        @(negedge clk);
        tests_run++; if (bus.o_overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_pulse_width: got %b expected 0", bus.o_overflow); end
        tx_model_en = 1'b1;
        wait_pulses(16, 4000);
        for (int i = 16; i < 32; i++) begin
            bus.i_wr    = 1'b1;
            bus.i_wdata = 8'(i);
            exp_q.push_back(8'(i));
            @(negedge clk);
        end
        bus.i_wr = 1'b0;
        wait_pulses(32, 7000);
        tests_run++; if (rec_q.size() != 32) begin tests_failed++; $display("FAIL wrap_pulse_count: got %0d expected 32", rec_q.size()); end
        for (int i = 0; i < 32; i++) begin
            got = (i < rec_q.size()) ? rec_q[i] : 'x;
            if (got === 8'hFF) ff_seen++;
            tests_run++; if (got !== exp_q[i]) begin tests_failed++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, got, exp_q[i]); end
        end
        tests_run++; if (ff_seen != 0) begin tests_failed++; $display("FAIL wrap_dropped_word_emitted: got %0d expected 0", ff_seen); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        drv_avail = 1'b0;
        write_word(8'h5A);
        tests_run++; if (bus.o_count !== 5'd1) begin tests_failed++; $display("FAIL sim_setup_count: got %0d expected 1", bus.o_count); end
        drv_avail   = 1'b1;                     // pop and write on the same edge
        bus.i_wr    = 1'b1;
        bus.i_wdata = 8'h6B;
        @(negedge clk);
        bus.i_wr  = 1'b0;
        drv_avail = 1'b0;
        tests_run++; if (bus.o_count !== 5'd1) begin tests_failed++; $display("FAIL sim_count: got %0d expected 1", bus.o_count); end
        tests_run++; if (bus.o_tx_data_ready !== 1'b1) begin tests_failed++; $display("FAIL sim_ready: got %b expected 1", bus.o_tx_data_ready); end
        tests_run++; if (bus.o_tx_data !== 8'h5A) begin tests_failed++; $display("FAIL sim_data: got %h expected 5a", bus.o_tx_data); end
        repeat (3) @(negedge clk);
        tests_run++; if (state_dbg !== ST_WAIT_DONE) begin tests_failed++; $display("FAIL sim_wait_done: got %b expected %b", state_dbg, ST_WAIT_DONE); end
        tests_run++; if (bus.o_tx_data_ready !== 1'b0) begin tests_failed++; $display("FAIL sim_no_pulse_busy: got %b expected 0", bus.o_tx_data_ready); end
        drv_avail = 1'b1;
        @(negedge clk);
        tests_run++; if (bus.o_tx_data_ready !== 1'b0) begin tests_failed++; $display("FAIL sim_idle_gap: got %b expected 0", bus.o_tx_data_ready); end
        @(negedge clk);
        tests_run++; if (bus.o_tx_data_ready !== 1'b1) begin tests_failed++; $display("FAIL sim_second_ready: got %b expected 1", bus.o_tx_data_ready); end
        tests_run++; if (bus.o_tx_data !== 8'h6B) begin tests_failed++; $display("FAIL sim_second_data: got %h expected 6b", bus.o_tx_data); end
        tests_run++; if (bus.o_count !== 5'd0) begin tests_failed++; $display("FAIL sim_final_count: got %0d expected 0", bus.o_count); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drv_avail = 1'b0;
        for (int i = 0; i < 6; i++) write_word(8'h40 + 8'(i));
        drv_avail = 1'b1;                       // pop one -> count 5, WAIT_BUSY
        @(negedge clk);
        drv_avail = 1'b0;                       // -> WAIT_DONE
        @(negedge clk);
        tests_run++; if (state_dbg !== ST_WAIT_DONE) begin tests_failed++; $display("FAIL mid_setup_state: got %b expected %b", state_dbg, ST_WAIT_DONE); end
        tests_run++; if (bus.o_count !== 5'd5) begin tests_failed++; $display("FAIL mid_setup_count: got %0d expected 5", bus.o_count); end
        rst       = 1'b1;
        drv_avail = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rec_q.delete();
        tests_run++; if (bus.o_count !== 5'd0) begin tests_failed++; $display("FAIL mid_count: got %0d expected 0", bus.o_count); end
        tests_run++; if (bus.o_empty !== 1'b1) begin tests_failed++; $display("FAIL mid_empty: got %b expected 1", bus.o_empty); end
        tests_run++; if (state_dbg !== ST_IDLE) begin tests_failed++; $display("FAIL mid_state: got %b expected %b", state_dbg, ST_IDLE); end
        tests_run++; if (bus.o_tx_data_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_ready: got %b expected 0", bus.o_tx_data_ready); end
        repeat (10) @(negedge clk);
        tests_run++; if (rec_q.size() != 0) begin tests_failed++; $display("FAIL mid_no_pulse_after_reset: got %0d expected 0", rec_q.size()); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.i_wr    = 1'b0;
        bus.i_wdata = '0;
        test_reset();
        test_single_latency();
        test_back_to_back();
        test_overflow_wrap();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
